reg_desp_univ: RTL and testbench

Parametrised universal shift register, the successor to the fixed 32-bit shift/rotate/load register. Adds a configurable width, arithmetic shift, and a multi-cycle burst rotate with a BUSY/DONE handshake. It sits on the datapath wherever a serial/parallel register is needed, and is verified against a behavioural model through a clocked checker, as for the 32-bit version.

---
 rtl/reg_desp_univ.sv | 108 ++++++++++
 tb/tb_reg_desp_univ.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_desp_univ.sv
// Parametrised universal shift register: logical/arithmetic shift, rotate,
// parallel load, and a multi-cycle burst rotate with BUSY/DONE handshake.
module reg_desp_univ #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 5
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic             DIR,
  input  logic [2:0]       MODO,
  input  logic             S_IN,
  input  logic             START,
  input  logic [AMT_W-1:0] AMT,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  typedef enum logic [2:0] {
    OP_HOLD, OP_SHIFT, OP_ROT, OP_LOAD, OP_ARITH, OP_BURST, OP_RSV6, OP_RSV7
  } op_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             bdir_q, bdir_d;
  op_t              op;

  assign op = op_t'(MODO);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    bdir_d  = bdir_q;
    case (state_q)
      RUN: begin
        if (ENB) begin
          if (bdir_q) q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          else        q_d = {q_q[0], q_q[WIDTH-1:1]};
          sout_d = bdir_q ? q_q[WIDTH-1] : q_q[0];
          cnt_d  = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) state_d = FIN;
        end
      end
      default: begin
        // FIN always falls back to IDLE unless a new burst is taken this edge
        state_d = IDLE;
        if (ENB) begin
          case (op)
            OP_SHIFT: begin
              if (DIR) q_d = {q_q[WIDTH-2:0], S_IN};
              else     q_d = {S_IN, q_q[WIDTH-1:1]};
              sout_d = DIR ? q_q[WIDTH-1] : q_q[0];
            end
            OP_ROT: begin
              if (DIR) q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
              else     q_d = {q_q[0], q_q[WIDTH-1:1]};
              sout_d = DIR ? q_q[WIDTH-1] : q_q[0];
            end
            OP_LOAD: q_d = D;
            OP_ARITH: begin
              if (DIR) q_d = {q_q[WIDTH-2:0], 1'b0};
              else     q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
              sout_d = DIR ? q_q[WIDTH-1] : q_q[0];
            end
            OP_BURST: begin
              if (START) begin
                bdir_d  = DIR;
                cnt_d   = AMT;
                state_d = (AMT != '0) ? RUN : FIN;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= IDLE;
      q_q     <= '0;
      sout_q  <= 1'b0;
      cnt_q   <= '0;
      bdir_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      cnt_q   <= cnt_d;
      bdir_q  <= bdir_d;
    end
  end

  assign Q     = q_q;
  assign S_OUT = sout_q;
  assign BUSY  = (state_q == RUN);
  assign DONE  = (state_q == FIN);

endmodule

// File: tb/tb_reg_desp_univ.sv
// Directed checks on an 8-bit instance, then randomized comparison of 32-bit
// and 5-bit instances against an arithmetic reference model.
module tb_reg_desp_univ;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_enb, a_dir, a_sin, a_start, a_so, a_busy, a_done;
  logic [2:0] a_modo;
  logic [3:0] a_amt;
  logic [7:0] a_d, a_q;

  logic        b_enb, b_dir, b_sin, b_start, b_so, b_busy, b_done;
  logic [2:0]  b_modo;
  logic [4:0]  b_amt;
  logic [31:0] b_d, b_q;

  logic       c_enb, c_dir, c_sin, c_start, c_so, c_busy, c_done;
  logic [2:0] c_modo;
  logic [2:0] c_amt;
  logic [4:0] c_d, c_q;

  int checks = 0;
  int errors = 0;

  reg_desp_univ #(.WIDTH(8), .AMT_W(4)) u8 (
    .CLK(clk), .RESET_L(rst_n), .ENB(a_enb), .DIR(a_dir), .MODO(a_modo),
    .S_IN(a_sin), .START(a_start), .AMT(a_amt), .D(a_d), .Q(a_q),
    .S_OUT(a_so), .BUSY(a_busy), .DONE(a_done));

  reg_desp_univ #(.WIDTH(32), .AMT_W(5)) u32 (
    .CLK(clk), .RESET_L(rst_n), .ENB(b_enb), .DIR(b_dir), .MODO(b_modo),
    .S_IN(b_sin), .START(b_start), .AMT(b_amt), .D(b_d), .Q(b_q),
    .S_OUT(b_so), .BUSY(b_busy), .DONE(b_done));

  reg_desp_univ #(.WIDTH(5), .AMT_W(3)) u5 (
    .CLK(clk), .RESET_L(rst_n), .ENB(c_enb), .DIR(c_dir), .MODO(c_modo),
    .S_IN(c_sin), .START(c_start), .AMT(c_amt), .D(c_d), .Q(c_q),
    .S_OUT(c_so), .BUSY(c_busy), .DONE(c_done));

  typedef struct {
    logic [31:0] q;
    logic        so;
    int          rem;
    logic        bdir;
    logic        run;
    logic        fin;
  } mdl_t;

  function automatic logic [31:0] msk(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] rotv(input logic [31:0] q, input logic left, input int w);
    if (left) return ((q << 1) | (q >> (w - 1))) & msk(w);
    return (q >> 1) | (32'(q[0]) << (w - 1));
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.q = '0; m.so = 1'b0; m.rem = 0; m.bdir = 1'b0; m.run = 1'b0; m.fin = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input int w, input logic enb,
                                    input logic dir, input logic [2:0] modo,
                                    input logic sin, input logic start,
                                    input int amt, input logic [31:0] d);
    mdl_t n;
    logic [31:0] mk;
    logic top, bot;
    n = m;
    mk = msk(w);
    top = m.q[w-1];
    bot = m.q[0];
    n.fin = 1'b0;
    if (m.run) begin
      if (enb) begin
        n.q = rotv(m.q, m.bdir, w);
        n.so = m.bdir ? top : bot;
        n.rem = m.rem - 1;
        if (n.rem == 0) begin n.run = 1'b0; n.fin = 1'b1; end
      end
    end else if (enb) begin
      case (modo)
        3'd1: begin
          n.q = dir ? (((m.q << 1) | 32'(sin)) & mk) : ((m.q >> 1) | (32'(sin) << (w - 1)));
          n.so = dir ? top : bot;
        end
        3'd2: begin n.q = rotv(m.q, dir, w); n.so = dir ? top : bot; end
        3'd3: n.q = d & mk;
        3'd4: begin
          n.q = dir ? ((m.q << 1) & mk) : ((m.q >> 1) | (32'(top) << (w - 1)));
          n.so = dir ? top : bot;
        end
        3'd5: if (start) begin
          n.bdir = dir;
          n.rem = amt;
          if (amt > 0) n.run = 1'b1;
          else         n.fin = 1'b1;
        end
        default: ;
      endcase
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic st8(input string tag, input logic [7:0] q, input logic busy, input logic done);
    chk({tag, "_q"}, 32'(a_q), 32'(q));
    chk({tag, "_busy"}, 32'(a_busy), 32'(busy));
    chk({tag, "_done"}, 32'(a_done), 32'(done));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  mdl_t mb, mc;

  initial begin
    a_enb = 0; a_dir = 0; a_sin = 0; a_start = 0; a_modo = 0; a_amt = 0; a_d = 0;
    b_enb = 0; b_dir = 0; b_sin = 0; b_start = 0; b_modo = 0; b_amt = 0; b_d = 0;
    c_enb = 0; c_dir = 0; c_sin = 0; c_start = 0; c_modo = 0; c_amt = 0; c_d = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    st8("reset", 8'h00, 1'b0, 1'b0);
    chk("reset_so", 32'(a_so), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // load / shift / rotate
    a_enb = 1; a_modo = 3'b011; a_d = 8'hA5; tick; st8("load", 8'hA5, 0, 0);
    a_modo = 3'b001; a_dir = 1; a_sin = 1; tick;
    st8("shl", 8'h4B, 0, 0); chk("shl_so", 32'(a_so), 32'd1);
    a_modo = 3'b010; a_dir = 0; tick;
    st8("rotr", 8'hA5, 0, 0); chk("rotr_so", 32'(a_so), 32'd1);

    // arithmetic
    a_modo = 3'b011; a_d = 8'h90; tick;
    a_modo = 3'b100; a_dir = 0; tick; st8("asr1", 8'hC8, 0, 0); chk("asr1_so", 32'(a_so), 32'd0);
    tick; st8("asr2", 8'hE4, 0, 0);
    a_modo = 3'b011; a_d = 8'h90; tick;
    a_modo = 3'b100; a_dir = 1; tick; st8("asl", 8'h20, 0, 0); chk("asl_so", 32'(a_so), 32'd1);

    // burst with MODO/D/DIR toggled while busy
    a_modo = 3'b011; a_d = 8'h01; tick;
    a_modo = 3'b101; a_start = 1; a_amt = 3; a_dir = 1; tick; st8("b_acc", 8'h01, 1, 0);
    a_modo = 3'b011; a_d = 8'hFF; a_dir = 0; a_start = 0; tick; st8("b_r1", 8'h02, 1, 0);
    a_modo = 3'b001; tick; st8("b_r2", 8'h04, 1, 0);
    tick; st8("b_r3", 8'h08, 0, 1); chk("b_so", 32'(a_so), 32'd0);
    a_modo = 3'b000; tick; st8("b_idle", 8'h08, 0, 0);

    // pause mid-burst
    a_modo = 3'b011; a_d = 8'h01; tick;
    a_modo = 3'b101; a_start = 1; a_amt = 3; a_dir = 1; tick; st8("p_acc", 8'h01, 1, 0);
    a_modo = 3'b000; a_start = 0; tick; st8("p_r1", 8'h02, 1, 0);
    a_enb = 0; tick; st8("p_hold1", 8'h02, 1, 0);
    tick; st8("p_hold2", 8'h02, 1, 0);
    a_enb = 1; tick; st8("p_r2", 8'h04, 1, 0);
    tick; st8("p_r3", 8'h08, 0, 1);
    tick; st8("p_idle", 8'h08, 0, 0);

    // zero-length burst
    a_modo = 3'b101; a_start = 1; a_amt = 0; tick; st8("z_fin", 8'h08, 0, 1);
    a_modo = 3'b000; a_start = 0; tick; st8("z_idle", 8'h08, 0, 0);

    // back-to-back bursts: START held into FIN
    a_modo = 3'b101; a_start = 1; a_amt = 1; a_dir = 0; tick; st8("bb_acc", 8'h08, 1, 0);
    tick; st8("bb_fin1", 8'h04, 0, 1);
    tick; st8("bb_acc2", 8'h04, 1, 0);
    a_modo = 3'b000; a_start = 0; tick; st8("bb_fin2", 8'h02, 0, 1);
    tick; st8("bb_idle", 8'h02, 0, 0);

    // burst count beyond WIDTH
    a_modo = 3'b011; a_d = 8'h81; tick;
    a_modo = 3'b101; a_start = 1; a_amt = 9; a_dir = 1; tick; st8("w_acc", 8'h81, 1, 0);
    a_modo = 3'b000; a_start = 0;
    for (int i = 0; i < 8; i++) begin tick; chk("w_busy", 32'(a_busy), 32'd1); end
    tick; st8("w_fin", 8'h03, 0, 1);
    tick;

    // reset during RUN
    a_modo = 3'b101; a_start = 1; a_amt = 5; a_dir = 1; tick; st8("r_acc", 8'h03, 1, 0);
    a_modo = 3'b000; a_start = 0; tick; st8("r_r1", 8'h06, 1, 0);
    rst_n = 1'b0; #1; st8("r_async", 8'h00, 0, 0); chk("r_so", 32'(a_so), 32'd0);
    tick; rst_n = 1'b1;
    tick; st8("r_after", 8'h00, 0, 0);
    tick; st8("r_after2", 8'h00, 0, 0);
    a_enb = 0;

    // randomized comparison against the reference model
    rst_n = 1'b0; tick; rst_n = 1'b1;
    mb = mdl_reset(); mc = mdl_reset();
    chk("rnd_rst_b_q", b_q, 32'd0);
    chk("rnd_rst_c_q", 32'(c_q), 32'd0);
    for (int i = 0; i < 10000; i++) begin
      b_enb = ($urandom_range(0, 9) != 0); b_dir = 1'($urandom); b_sin = 1'($urandom);
      b_start = 1'($urandom); b_modo = 3'($urandom); b_amt = 5'($urandom); b_d = $urandom;
      c_enb = ($urandom_range(0, 9) != 0); c_dir = 1'($urandom); c_sin = 1'($urandom);
      c_start = 1'($urandom); c_modo = 3'($urandom); c_amt = 3'($urandom); c_d = 5'($urandom);
      mb = mdl_next(mb, 32, b_enb, b_dir, b_modo, b_sin, b_start, int'(b_amt), b_d);
      mc = mdl_next(mc, 5, c_enb, c_dir, c_modo, c_sin, c_start, int'(c_amt), 32'(c_d));
      tick;
      chk("w32_q", b_q, mb.q);
      chk("w32_so", 32'(b_so), 32'(mb.so));
      chk("w32_busy", 32'(b_busy), 32'(mb.run));
      chk("w32_done", 32'(b_done), 32'(mb.fin));
      chk("w5_q", 32'(c_q), mc.q);
      chk("w5_so", 32'(c_so), 32'(mc.so));
      chk("w5_busy", 32'(c_busy), 32'(mc.run));
      chk("w5_done", 32'(c_done), 32'(mc.fin));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
